branch_predictor: RTL

Parametrised direct-mapped branch target buffer (BTB) with per-entry saturating direction counters for the pipelined datapath.
- Fetch side: gives a same-cycle predicted next PC for the current imemaddr.
- Execute/memory side: takes resolved-branch updates and trains the tables.
- Lets the fetch mux select a predicted target instead of always fetching PC+4 and flushing on taken branches.

---
 rtl/branch_predictor_pkg.sv | 57 +++++
 rtl/bp_sat_counter.sv | 23 ++
 rtl/branch_predictor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared types and helpers for the branch target buffer.
//   btb_entry_t    : one BTB entry (valid, tag, target, direction counter).
//                    Fields are sized for the widest supported build; a given
//                    instance only uses the low WORD_W / TAG_W / CTR_W bits.
//                    The unused high bits are held at zero.
//   ctr_weak_nt()  : "weakly not-taken" counter value for a given width.
//   ctr_weak_t()   : "weakly taken" counter value for a given width.
//   sat_ctr_next() : saturating up/down step of a direction counter.
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

    localparam int unsigned BP_MAX_W     = 64;
    localparam int unsigned BP_MAX_CTR_W = 8;

    typedef struct packed {
        logic                    valid;
        logic [BP_MAX_W-1:0]     tag;
        logic [BP_MAX_W-1:0]     target;
        logic [BP_MAX_CTR_W-1:0] ctr;
    } btb_entry_t;

    // Largest value with MSB clear: 01 for 2 bits, 0 for a 1-bit counter.
    function automatic logic [BP_MAX_CTR_W-1:0] ctr_weak_nt(input int unsigned width);
        logic [BP_MAX_CTR_W:0] v;
        v = (9'd1 << (width - 32'd1)) - 9'd1;
        return v[BP_MAX_CTR_W-1:0];
    endfunction

    // Smallest value with MSB set: 10 for 2 bits, 1 for a 1-bit counter.
    function automatic logic [BP_MAX_CTR_W-1:0] ctr_weak_t(input int unsigned width);
        logic [BP_MAX_CTR_W:0] v;
        v = 9'd1 << (width - 32'd1);
        return v[BP_MAX_CTR_W-1:0];
    endfunction

    // Move the counter one step toward the outcome without wrapping.
    function automatic logic [BP_MAX_CTR_W-1:0] sat_ctr_next(
        input logic [BP_MAX_CTR_W-1:0] ctr,
        input logic                    taken,
        input int unsigned             width
    );
        logic [BP_MAX_CTR_W:0]   max_full;
        logic [BP_MAX_CTR_W-1:0] max_v;
        logic [BP_MAX_CTR_W-1:0] res;
        max_full = (9'd1 << width) - 9'd1;
        max_v    = max_full[BP_MAX_CTR_W-1:0];
        if (taken) begin
            res = (ctr >= max_v) ? max_v : ctr + 8'd1;
        end else begin
            res = (ctr == 8'd0) ? 8'd0 : ctr - 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// -----------------------------------------------------------------------------
// bp_sat_counter
// Purely combinational next-state of one saturating direction counter.
//   i_ctr      : current counter value
//   i_taken    : resolved outcome (1 = count up, 0 = count down)
//   o_ctr_next : saturated next value
// -----------------------------------------------------------------------------
module bp_sat_counter
    import branch_predictor_pkg::*;
#(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] i_ctr,
    input  logic             i_taken,
    output logic [CTR_W-1:0] o_ctr_next
);

    // Next counter value, computed at full helper width and narrowed back.
    always_comb begin
        o_ctr_next = CTR_W'(sat_ctr_next(BP_MAX_CTR_W'(i_ctr), i_taken, CTR_W));
    end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Fetch gets a same-cycle predicted next PC; resolved branches from
// the back end train the table on the clock edge.
//
// Ports
//   CLK, RST          : clock, synchronous active-high reset
//   lookup_pc         : current fetch address
//   pred_hit          : valid entry with matching tag
//   pred_taken        : hit and counter MSB set
//   pred_target       : stored target when predicted taken, else lookup_pc+4
//   upd_valid/upd_pc/upd_taken/upd_target/upd_mispredict : resolved branch
//   flush_all         : invalidate every entry (dominates an update)
//   stat_lookups      : saturating count of cycles with pred_hit
//   stat_mispredicts  : saturating count of upd_valid & upd_mispredict
//
// Build option
//   BP_UPDATE_BYPASS_EN : when defined, a lookup to the same index as a
//   concurrent update sees the post-update entry in the same cycle.
// -----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter  int unsigned ENTRIES = 16,
    parameter  int unsigned WORD_W  = 32,
    parameter  int unsigned CTR_W   = 2,
    localparam int unsigned IDX_W   = $clog2(ENTRIES),
    localparam int unsigned TAG_W   = WORD_W - IDX_W - 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [WORD_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [WORD_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [WORD_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              flush_all,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_mispredicts
);

    btb_entry_t          r_table [ENTRIES];
    logic [31:0]         r_stat_lookups;
    logic [31:0]         r_stat_mispredicts;

    logic [IDX_W-1:0]    w_lookup_idx;
    logic [IDX_W-1:0]    w_upd_idx;
    logic [BP_MAX_W-1:0] w_lookup_tag;
    logic [BP_MAX_W-1:0] w_upd_tag;

    btb_entry_t          w_upd_cur;
    btb_entry_t          w_upd_next;
    logic                w_upd_hit;
    logic                w_upd_we;
    logic [CTR_W-1:0]    w_ctr_next;
    btb_entry_t          w_look_entry;

    // Index from the word-address bits, tag from everything above; bits [1:0] ignored.
    always_comb begin
        w_lookup_idx = lookup_pc[IDX_W+1:2];
        w_upd_idx    = upd_pc[IDX_W+1:2];
        w_lookup_tag = BP_MAX_W'(lookup_pc[WORD_W-1:IDX_W+2]);
        w_upd_tag    = BP_MAX_W'(upd_pc[WORD_W-1:IDX_W+2]);
    end

    // Only the entry addressed by the update can change, so one counter suffices.
    bp_sat_counter #(
        .CTR_W (CTR_W)
    ) u_sat_counter (
        .i_ctr      (w_upd_cur.ctr[CTR_W-1:0]),
        .i_taken    (upd_taken),
        .o_ctr_next (w_ctr_next)
    );

    // Post-update image of the addressed entry and its write enable.
    always_comb begin
        w_upd_cur  = r_table[w_upd_idx];
        w_upd_hit  = w_upd_cur.valid && (w_upd_cur.tag == w_upd_tag);
        w_upd_next = w_upd_cur;
        w_upd_we   = 1'b0;
        if (upd_valid && !flush_all) begin
            if (w_upd_hit) begin
                w_upd_we       = 1'b1;
                w_upd_next.ctr = BP_MAX_CTR_W'(w_ctr_next);
                if (upd_taken) begin
                    w_upd_next.target = BP_MAX_W'(upd_target);
                end else begin
                    w_upd_next.target = w_upd_cur.target;
                end
            end else if (upd_taken) begin
                // Allocation replaces whatever occupied the slot.
                w_upd_we          = 1'b1;
                w_upd_next.valid  = 1'b1;
                w_upd_next.tag    = w_upd_tag;
                w_upd_next.target = BP_MAX_W'(upd_target);
                w_upd_next.ctr    = ctr_weak_t(CTR_W);
            end else begin
                w_upd_we = 1'b0;
            end
        end else begin
            w_upd_we = 1'b0;
        end
    end

    // Entry seen by the fetch-side lookup.
    always_comb begin
        w_look_entry = r_table[w_lookup_idx];
`ifdef BP_UPDATE_BYPASS_EN
        if (upd_valid && (w_upd_idx == w_lookup_idx)) begin
            if (flush_all) begin
                w_look_entry.valid = 1'b0;
            end else begin
                w_look_entry = w_upd_next;
            end
        end else begin
            w_look_entry = r_table[w_lookup_idx];
        end
`endif
    end

    // Zero-latency prediction; PC+4 wraps modulo 2^WORD_W.
    always_comb begin
        pred_hit    = w_look_entry.valid && (w_look_entry.tag == w_lookup_tag);
        pred_taken  = pred_hit && w_look_entry.ctr[CTR_W-1];
        if (pred_taken) begin
            pred_target = WORD_W'(w_look_entry.target);
        end else begin
            pred_target = lookup_pc + WORD_W'(32'd4);
        end
    end

    // Table write: reset first, then flush (drops any update), then the update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_table[i].valid  <= 1'b0;
                r_table[i].tag    <= '0;
                r_table[i].target <= '0;
                r_table[i].ctr    <= ctr_weak_nt(CTR_W);
            end
        end else if (flush_all) begin
            // Only valid bits are cleared; tag, target and counter survive.
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_table[i].valid <= 1'b0;
            end
        end else if (w_upd_we) begin
            r_table[w_upd_idx] <= w_upd_next;
        end else begin
            r_table[w_upd_idx] <= r_table[w_upd_idx];
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_lookups     <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            if (pred_hit && (r_stat_lookups != 32'hFFFF_FFFF)) begin
                r_stat_lookups <= r_stat_lookups + 32'd1;
            end else begin
                r_stat_lookups <= r_stat_lookups;
            end
            if (upd_valid && upd_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end else begin
                r_stat_mispredicts <= r_stat_mispredicts;
            end
        end
    end

    assign stat_lookups     = r_stat_lookups;
    assign stat_mispredicts = r_stat_mispredicts;

endmodule
